// File: rtl/conv55_pkg.sv
// Shared constants, tap indexing and FSM state type for the 5x5 conv window path.
package conv55_pkg;

  localparam int K         = 5;
  localparam int NTAP      = 25;
  localparam int PIX_W_DEF = 6;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } wg_state_t;

  function automatic int tap_idx(input int r, input int c);
    return K * r + c;
  endfunction

endpackage

// File: rtl/conv55_row_delay.sv
// One-row pixel delay line: circular RAM addressed by a single wrap-around pointer.
// dout is the pixel written DEPTH enabled cycles ago; contents are never cleared.
module conv55_row_delay #(
  parameter int PIX_W = 6,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same slot yields exactly one row of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/conv55_window_gen.sv
// Streaming 5x5 window generator over raster pixels, 1-clk registered window output.
// Macro CONV55_WINGEN_BACKPRESSURE_EN adds out_ready; otherwise in_ready=1 and every strobe must be taken.
module conv55_window_gen
  import conv55_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [PIX_W-1:0]      in_pixel,
  output logic                  in_ready,
`ifdef CONV55_WINGEN_BACKPRESSURE_EN
  input  logic                  out_ready,
`endif
  output logic                  out_valid,
  output logic [NTAP*PIX_W-1:0] win_data,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K - 2);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  wg_state_t             state;
  wg_state_t             state_nxt;
  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  win_load;
  logic                  frame_end;
  logic [PIX_W-1:0]      dly_in  [K-1];
  logic [PIX_W-1:0]      dly_out [K-1];
  logic [PIX_W-1:0]      col_in  [K];
  logic [PIX_W-1:0]      win     [K][K];
  logic [PIX_W-1:0]      win_nxt [K][K];
  logic [NTAP*PIX_W-1:0] win_flat;

  assign accept   = in_valid & in_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // Raster position of the pixel currently on in_pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Four chained row delays; delay i outputs the pixel i+1 rows above the input.
  assign dly_in[0] = in_pixel;
  for (genvar i = 1; i < K - 1; i++) begin : g_chain
    assign dly_in[i] = dly_out[i-1];
  end

  for (genvar i = 0; i < K - 1; i++) begin : g_dly
    conv55_row_delay #(
      .PIX_W (PIX_W),
      .DEPTH (IMG_W)
    ) u_row_delay (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (dly_in[i]),
      .dout (dly_out[i])
    );
  end

  // Column entering the window: oldest row at the top, the live pixel at the bottom.
  for (genvar r = 0; r < K - 1; r++) begin : g_col
    assign col_in[r] = dly_out[K-2-r];
  end
  assign col_in[K-1] = in_pixel;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
      win_nxt[r][K-1] = col_in[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win <= win_nxt;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[PIX_W*tap_idx(r, c) +: PIX_W] = win_nxt[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    win_load  = 1'b0;
    frame_end = 1'b0;
    case (state)
      FILL: begin
        if (accept && row == ROW_FILL_LAST && col_last) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Leftmost four columns of a row would straddle the previous row.
        win_load = accept && (col >= COL_FIRST_WIN);
        if (accept && row_last && col_last) begin
          state_nxt = FILL;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (win_load) begin
        win_data <= win_flat;
      end
    end
  end

`ifdef CONV55_WINGEN_BACKPRESSURE_EN
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (win_load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= win_load;
    end
  end
`endif

endmodule

// File: tb/tb_conv55_window_gen.sv
// Bench for conv55_window_gen: raster streams vs an image-array window model, plus a 5x5-geometry instance.
module tb_conv55_window_gen;
  import conv55_pkg::*;

  localparam int PW = 6;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int HW = W * H;
  localparam int WB = NTAP * PW;
  localparam int NWIN = (W - 4) * (H - 4);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [PW-1:0] in_pixel;
  logic          in_ready;
  logic          out_valid;
  logic [WB-1:0] win_data;
  logic          frame_done;

  logic          s_valid;
  logic [PW-1:0] s_pixel;
  logic          s_ready;
  logic          s_out_valid;
  logic [WB-1:0] s_win;
  logic          s_frame_done;
`ifdef CONV55_WINGEN_BACKPRESSURE_EN
  logic          out_ready;
  logic          s_out_ready;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [PW-1:0] img [2][H][W];
  int            first_acc [2];
  logic [WB-1:0] first_win [2];

  always #5 clk = ~clk;

  conv55_window_gen #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
`ifdef CONV55_WINGEN_BACKPRESSURE_EN
    .out_ready  (out_ready),
`endif
    .out_valid  (out_valid),
    .win_data   (win_data),
    .frame_done (frame_done)
  );

  conv55_window_gen #(.PIX_W(PW), .IMG_W(5), .IMG_H(5)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_valid),
    .in_pixel   (s_pixel),
    .in_ready   (s_ready),
`ifdef CONV55_WINGEN_BACKPRESSURE_EN
    .out_ready  (s_out_ready),
`endif
    .out_valid  (s_out_valid),
    .win_data   (s_win),
    .frame_done (s_frame_done)
  );

  // Window for a pixel accepted at (R,C): tap 5r+c holds image pixel (R-4+r, C-4+c).
  function automatic logic [WB-1:0] exp_window(input int f, input int rr, input int cc);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[PW*(5*r+c) +: PW] = img[f][rr-4+r][cc-4+c];
    return w;
  endfunction

  function automatic void fill_ramp(input int f);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[f][r][c] = PW'((r + c) & 63);
  endfunction

  function automatic void fill_random(input int f);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[f][r][c] = PW'($urandom);
  endfunction

  // Streams frames of img[] with random gaps; model holds the window until consumed.
  task automatic stream(input int nfr, input int gap_pct, input int stop_px, input int stall_win,
                        input bit drain, output int strobes, output int fdones);
    int total, done, wins, stall, r, c, f, fa;
    bit v, ordy, rdy, acc, exp_fd;
    logic exp_vld;
    logic [WB-1:0] exp_win;
    total = (stop_px >= 0) ? stop_px : nfr * HW;
    done = 0; wins = 0; stall = 0; strobes = 0; fdones = 0;
    exp_vld = 1'b0; exp_win = '0;
    first_acc[0] = -1; first_acc[1] = -1;
    while (done < total) begin
      f = done / HW; r = (done % HW) / W; c = done % W;
      v = ($urandom_range(99) >= gap_pct);
      ordy = (stall == 0);
      if (stall > 0) stall--;
      in_valid = v;
      in_pixel = v ? img[f][r][c] : PW'($urandom);
`ifdef CONV55_WINGEN_BACKPRESSURE_EN
      out_ready = ordy;
`endif
      #1;
      rdy = !exp_vld || ordy;
      n_vec++;
      if (in_ready !== rdy) begin
        n_err++;
        $display("FAIL in_ready px=%0d got=%b exp=%b", done, in_ready, rdy);
      end
      acc = v && rdy;
      if (exp_vld && ordy) strobes++;
      exp_fd = acc && (r == H - 1) && (c == W - 1);
      if (acc && r >= 4 && c >= 4) begin
        exp_vld = 1'b1;
        exp_win = exp_window(f, r, c);
        wins++;
        if (wins == stall_win) stall = 20;
      end else if (ordy) begin
        exp_vld = 1'b0;
      end
      if (acc) done++;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== exp_vld) begin
        n_err++;
        $display("FAIL out_valid acc=%0d got=%b exp=%b", done, out_valid, exp_vld);
      end
      if (exp_vld) begin
        n_vec++;
        if (win_data !== exp_win) begin
          n_err++;
          $display("FAIL win_data acc=%0d got=%h exp=%h", done, win_data, exp_win);
        end
      end
      n_vec++;
      if (frame_done !== exp_fd) begin
        n_err++;
        $display("FAIL frame_done acc=%0d got=%b exp=%b", done, frame_done, exp_fd);
      end
      if (frame_done === 1'b1) fdones++;
      if (acc && out_valid === 1'b1) begin
        fa = (done - 1) / HW;
        if (first_acc[fa] < 0) begin
          first_acc[fa] = (done - 1) % HW + 1;
          first_win[fa] = win_data;
        end
      end
    end
    if (drain) begin
      in_valid = 1'b0;
`ifdef CONV55_WINGEN_BACKPRESSURE_EN
      out_ready = 1'b1;
`endif
      #1;
      if (exp_vld) strobes++;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL drain_idle got vld=%b fd=%b exp 0 0", out_valid, frame_done);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; s_valid = 1'b0; s_pixel = '0;
`ifdef CONV55_WINGEN_BACKPRESSURE_EN
    out_ready = 1'b1; s_out_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state got vld=%b fd=%b win=%h rdy=%b exp 0 0 0 1",
               out_valid, frame_done, win_data, in_ready);
    end
    n_vec++;
    if (s_out_valid !== 1'b0 || s_frame_done !== 1'b0 || s_win !== '0 || s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_small got vld=%b fd=%b rdy=%b exp 0 0 1", s_out_valid, s_frame_done, s_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp;
    int strobes, fdones;
    logic [WB-1:0] w;
    fill_ramp(0);
    stream(1, 0, -1, -1, 1'b1, strobes, fdones);
    w = first_win[0];
    n_vec++;
    if (strobes !== NWIN) begin n_err++; $display("FAIL ramp_strobes got=%0d exp=%0d", strobes, NWIN); end
    n_vec++;
    if (fdones !== 1) begin n_err++; $display("FAIL ramp_frame_done got=%0d exp=1", fdones); end
    n_vec++;
    if (first_acc[0] !== 133) begin n_err++; $display("FAIL ramp_first_win got=%0d exp=133", first_acc[0]); end
    n_vec++;
    if (w[0 +: PW] !== PW'(0) || w[PW*24 +: PW] !== PW'(8) || w[PW*4 +: PW] !== PW'(4)) begin
      n_err++;
      $display("FAIL ramp_slices got s0=%0d s24=%0d s4=%0d exp 0 8 4", w[0 +: PW], w[PW*24 +: PW], w[PW*4 +: PW]);
    end
  endtask

  task automatic test_gaps;
    int strobes, fdones;
    fill_ramp(0);
    stream(1, 50, -1, -1, 1'b1, strobes, fdones);
    n_vec++;
    if (strobes !== NWIN || fdones !== 1) begin
      n_err++;
      $display("FAIL gaps_counts got strobes=%0d fd=%0d exp %0d 1", strobes, fdones, NWIN);
    end
  endtask

  task automatic test_back_to_back;
    int strobes, fdones;
    fill_ramp(0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[1][r][c] = PW'((3 * r + 5 * c) & 63);
    stream(2, 0, -1, -1, 1'b1, strobes, fdones);
    n_vec++;
    if (strobes !== 2 * NWIN || fdones !== 2) begin
      n_err++;
      $display("FAIL b2b_counts got strobes=%0d fd=%0d exp %0d 2", strobes, fdones, 2 * NWIN);
    end
    n_vec++;
    if (first_acc[1] !== 133 || first_win[1][0 +: PW] !== PW'(0)) begin
      n_err++;
      $display("FAIL b2b_frame2_first got acc=%0d s0=%0d exp 133 0", first_acc[1], first_win[1][0 +: PW]);
    end
  endtask

  task automatic test_random_pixels;
    int strobes, fdones;
    fill_random(0);
    fill_random(1);
    stream(2, 30, -1, -1, 1'b1, strobes, fdones);
    n_vec++;
    if (strobes !== 2 * NWIN || fdones !== 2) begin
      n_err++;
      $display("FAIL rand_counts got strobes=%0d fd=%0d exp %0d 2", strobes, fdones, 2 * NWIN);
    end
  endtask

  task automatic test_reset_midframe;
    int strobes, fdones;
    fill_ramp(0);
    stream(1, 0, 10 * W + 17 + 1, -1, 1'b0, strobes, fdones);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL midframe_pre_rst got vld=%b exp 1", out_valid); end
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || win_data !== '0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_async_rst got vld=%b win=%h fd=%b rdy=%b exp 0 0 0 1",
               out_valid, win_data, frame_done, in_ready);
    end
    #2;
    rst = 1'b0;
    stream(1, 20, -1, -1, 1'b1, strobes, fdones);
    n_vec++;
    if (first_acc[0] !== 133 || strobes !== NWIN || fdones !== 1) begin
      n_err++;
      $display("FAIL midframe_restart got first=%0d strobes=%0d fd=%0d exp 133 %0d 1",
               first_acc[0], strobes, fdones, NWIN);
    end
  endtask

`ifdef CONV55_WINGEN_BACKPRESSURE_EN
  task automatic test_backpressure;
    int strobes, fdones;
    fill_random(0);
    stream(1, 0, -1, 5, 1'b1, strobes, fdones);
    n_vec++;
    if (strobes !== NWIN || fdones !== 1) begin
      n_err++;
      $display("FAIL bp_counts got strobes=%0d fd=%0d exp %0d 1", strobes, fdones, NWIN);
    end
  endtask
`endif

  task automatic test_small;
    logic [PW-1:0] got;
    for (int i = 0; i < 25; i++) begin
      s_valid = 1'b1;
      s_pixel = PW'(i);
      @(posedge clk); #1;
      n_vec++;
      if (s_out_valid !== (i == 24) || s_frame_done !== (i == 24)) begin
        n_err++;
        $display("FAIL small_strobe px=%0d got vld=%b fd=%b exp %0d", i, s_out_valid, s_frame_done, i == 24);
      end
    end
    for (int k = 0; k < 25; k++) begin
      got = s_win[PW*k +: PW];
      n_vec++;
      if (got !== PW'(k)) begin n_err++; $display("FAIL small_slice k=%0d got=%0d exp=%0d", k, got, k); end
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (s_out_valid !== 1'b0 || s_frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL small_after got vld=%b fd=%b exp 0 0", s_out_valid, s_frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_random_pixels();
    test_reset_midframe();
`ifdef CONV55_WINGEN_BACKPRESSURE_EN
    test_backpressure();
`endif
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
